// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage core.
// It captures decoded controls and operands, resolves the destination register,
// detects load-use hazards against the load already in EX, and inserts bubbles on
// flush or stall. A global hold freezes everything. The number of load-use
// bubbles is kept in a saturating counter.
module id_ex_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,

  // Decode controls
  input  logic        i_RegWr,
  input  logic        i_Branch,
  input  logic        i_BranchClip,
  input  logic        i_Jump,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic        i_ALUSrcA,
  input  logic        i_ALUSrcB,
  input  logic        i_LuiOp,
  input  logic        i_SignedOp,
  input  logic [1:0]  i_MemtoReg,
  input  logic [3:0]  i_ALUOp,
  input  logic [1:0]  i_RegDst,

  // ID data
  input  logic        i_Valid,
  input  logic [31:0] i_PC4,
  input  logic [31:0] i_RData1,
  input  logic [31:0] i_RData2,
  input  logic [31:0] i_Imm32,
  input  logic [4:0]  i_Rs,
  input  logic [4:0]  i_Rt,
  input  logic [4:0]  i_Rd,
  input  logic [4:0]  i_Shamt,

  // Pipeline control
  input  logic        i_Flush,
  input  logic        i_Hold,

  // EX copies of the decode controls
  output logic        o_RegWr,
  output logic        o_Branch,
  output logic        o_BranchClip,
  output logic        o_Jump,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic        o_ALUSrcA,
  output logic        o_ALUSrcB,
  output logic        o_LuiOp,
  output logic        o_SignedOp,
  output logic [1:0]  o_MemtoReg,
  output logic [3:0]  o_ALUOp,
  output logic [1:0]  o_RegDst,

  // EX data
  output logic [31:0] o_PC4,
  output logic [31:0] o_RData1,
  output logic [31:0] o_RData2,
  output logic [31:0] o_Imm32,
  output logic [4:0]  o_Rs,
  output logic [4:0]  o_Rt,
  output logic [4:0]  o_Shamt,
  output logic [4:0]  o_WrAddr,
  output logic        o_Valid,

  // Hazard status
  output logic        o_Stall,
  output logic [15:0] o_StallCnt
);

  // Decode controls travel together so bubbles can clear the relevant ones in one place.
  typedef struct packed {
    logic       regWr;
    logic       branch;
    logic       branchClip;
    logic       jump;
    logic       memRead;
    logic       memWrite;
    logic       aluSrcA;
    logic       aluSrcB;
    logic       luiOp;
    logic       signedOp;
    logic [1:0] memtoReg;
    logic [3:0] aluOp;
    logic [1:0] regDst;
  } ctrl_t;

  // What the register bank does on the next rising edge.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_FLUSH,
    ACT_STALL,
    ACT_LOAD
  } action_e;

  ctrl_t       idCtrl;
  ctrl_t       ctrl_q,     ctrl_d;
  logic [31:0] pc4_q,      pc4_d;
  logic [31:0] rData1_q,   rData1_d;
  logic [31:0] rData2_q,   rData2_d;
  logic [31:0] imm32_q,    imm32_d;
  logic [4:0]  rs_q,       rs_d;
  logic [4:0]  rt_q,       rt_d;
  logic [4:0]  shamt_q,    shamt_d;
  logic [4:0]  wrAddr_q,   wrAddr_d;
  logic        valid_q,    valid_d;
  logic [15:0] stallCnt_q, stallCnt_d;

  logic [4:0]  idWrAddr;
  logic        rtRead;
  logic        luh;
  action_e     action;

  // Gather the incoming decode controls into one bundle.
  always_comb begin
    idCtrl            = '0;
    idCtrl.regWr      = i_RegWr;
    idCtrl.branch     = i_Branch;
    idCtrl.branchClip = i_BranchClip;
    idCtrl.jump       = i_Jump;
    idCtrl.memRead    = i_MemRead;
    idCtrl.memWrite   = i_MemWrite;
    idCtrl.aluSrcA    = i_ALUSrcA;
    idCtrl.aluSrcB    = i_ALUSrcB;
    idCtrl.luiOp      = i_LuiOp;
    idCtrl.signedOp   = i_SignedOp;
    idCtrl.memtoReg   = i_MemtoReg;
    idCtrl.aluOp      = i_ALUOp;
    idCtrl.regDst     = i_RegDst;
  end

  // Pick the destination register for the instruction in ID (11 is unused and maps to $0).
  always_comb begin
    idWrAddr = 5'd0;
    case (i_RegDst)
      2'b00:   idWrAddr = i_Rd;
      2'b01:   idWrAddr = i_Rt;
      2'b10:   idWrAddr = 5'd31;
      default: idWrAddr = 5'd0;
    endcase
  end

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // rt only counts as a source for R-type ALU ops, stores and branches.
  always_comb begin
    rtRead = ~i_ALUSrcB | i_MemWrite | i_Branch;
    luh    = valid_q & ctrl_q.memRead & (wrAddr_q != 5'd0) & i_Valid &
             ((wrAddr_q == i_Rs) | ((wrAddr_q == i_Rt) & rtRead));
  end

  // Priority: hold beats flush, flush beats a load-use stall, otherwise load normally.
  always_comb begin
    if (i_Hold) begin
      action = ACT_HOLD;
    end else if (i_Flush) begin
      action = ACT_FLUSH;
    end else if (luh) begin
      action = ACT_STALL;
    end else begin
      action = ACT_LOAD;
    end
  end

  assign o_Stall = (action == ACT_STALL);

  // Next-state for the EX register bank and the saturating bubble counter.
  always_comb begin
    ctrl_d     = ctrl_q;
    pc4_d      = pc4_q;
    rData1_d   = rData1_q;
    rData2_d   = rData2_q;
    imm32_d    = imm32_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    shamt_d    = shamt_q;
    wrAddr_d   = wrAddr_q;
    valid_d    = valid_q;
    stallCnt_d = stallCnt_q;

    if (action != ACT_HOLD) begin
      ctrl_d   = idCtrl;
      pc4_d    = i_PC4;
      rData1_d = i_RData1;
      rData2_d = i_RData2;
      imm32_d  = i_Imm32;
      rs_d     = i_Rs;
      rt_d     = i_Rt;
      shamt_d  = i_Shamt;
      wrAddr_d = idWrAddr;
      valid_d  = i_Valid;

      // A bubble, or an empty ID slot, must not write registers, touch memory or redirect the PC.
      if ((action != ACT_LOAD) || !i_Valid) begin
        ctrl_d.regWr      = 1'b0;
        ctrl_d.branch     = 1'b0;
        ctrl_d.branchClip = 1'b0;
        ctrl_d.jump       = 1'b0;
        ctrl_d.memRead    = 1'b0;
        ctrl_d.memWrite   = 1'b0;
        wrAddr_d          = 5'd0;
        valid_d           = 1'b0;
      end
    end

    if ((action == ACT_STALL) && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  // EX register bank, cleared asynchronously by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q     <= '0;
      pc4_q      <= '0;
      rData1_q   <= '0;
      rData2_q   <= '0;
      imm32_q    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      shamt_q    <= '0;
      wrAddr_q   <= '0;
      valid_q    <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc4_q      <= pc4_d;
      rData1_q   <= rData1_d;
      rData2_q   <= rData2_d;
      imm32_q    <= imm32_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      shamt_q    <= shamt_d;
      wrAddr_q   <= wrAddr_d;
      valid_q    <= valid_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign o_RegWr      = ctrl_q.regWr;
  assign o_Branch     = ctrl_q.branch;
  assign o_BranchClip = ctrl_q.branchClip;
  assign o_Jump       = ctrl_q.jump;
  assign o_MemRead    = ctrl_q.memRead;
  assign o_MemWrite   = ctrl_q.memWrite;
  assign o_ALUSrcA    = ctrl_q.aluSrcA;
  assign o_ALUSrcB    = ctrl_q.aluSrcB;
  assign o_LuiOp      = ctrl_q.luiOp;
  assign o_SignedOp   = ctrl_q.signedOp;
  assign o_MemtoReg   = ctrl_q.memtoReg;
  assign o_ALUOp      = ctrl_q.aluOp;
  assign o_RegDst     = ctrl_q.regDst;
  assign o_PC4        = pc4_q;
  assign o_RData1     = rData1_q;
  assign o_RData2     = rData2_q;
  assign o_Imm32      = imm32_q;
  assign o_Rs         = rs_q;
  assign o_Rt         = rt_q;
  assign o_Shamt      = shamt_q;
  assign o_WrAddr     = wrAddr_q;
  assign o_Valid      = valid_q;
  assign o_StallCnt   = stallCnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a reference model predicts the EX register
// contents for every driven ID instruction, the prediction is queued and compared
// one edge later, and directed scenarios add constant checks on top.
module tb_id_ex_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_RegWr, i_Branch, i_BranchClip, i_Jump, i_MemRead, i_MemWrite;
  logic        i_ALUSrcA, i_ALUSrcB, i_LuiOp, i_SignedOp;
  logic [1:0]  i_MemtoReg;
  logic [3:0]  i_ALUOp;
  logic [1:0]  i_RegDst;
  logic        i_Valid;
  logic [31:0] i_PC4, i_RData1, i_RData2, i_Imm32;
  logic [4:0]  i_Rs, i_Rt, i_Rd, i_Shamt;
  logic        i_Flush, i_Hold;
  logic        o_RegWr, o_Branch, o_BranchClip, o_Jump, o_MemRead, o_MemWrite;
  logic        o_ALUSrcA, o_ALUSrcB, o_LuiOp, o_SignedOp;
  logic [1:0]  o_MemtoReg;
  logic [3:0]  o_ALUOp;
  logic [1:0]  o_RegDst;
  logic [31:0] o_PC4, o_RData1, o_RData2, o_Imm32;
  logic [4:0]  o_Rs, o_Rt, o_Shamt, o_WrAddr;
  logic        o_Valid, o_Stall;
  logic [15:0] o_StallCnt;

  typedef struct packed {
    logic        regWr, branch, branchClip, jump, memRead, memWrite;
    logic        aluSrcA, aluSrcB, luiOp, signedOp;
    logic [1:0]  memtoReg;
    logic [3:0]  aluOp;
    logic [1:0]  regDst;
    logic        valid;
    logic [31:0] pc4, rData1, rData2, imm32;
    logic [4:0]  rs, rt, rd, shamt;
    logic        flush, hold;
  } idIn_t;

  typedef struct packed {
    logic        regWr, branch, branchClip, jump, memRead, memWrite;
    logic        aluSrcA, aluSrcB, luiOp, signedOp;
    logic [1:0]  memtoReg;
    logic [3:0]  aluOp;
    logic [1:0]  regDst;
    logic [31:0] pc4, rData1, rData2, imm32;
    logic [4:0]  rs, rt, shamt, wrAddr;
    logic        valid;
    logic [15:0] stallCnt;
  } exOut_t;

  int     numChecks = 0;
  int     numFails  = 0;
  exOut_t mdl;
  exOut_t expQ[$];

  id_ex_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_RegWr(i_RegWr), .i_Branch(i_Branch), .i_BranchClip(i_BranchClip), .i_Jump(i_Jump),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_ALUSrcA(i_ALUSrcA), .i_ALUSrcB(i_ALUSrcB),
    .i_LuiOp(i_LuiOp), .i_SignedOp(i_SignedOp), .i_MemtoReg(i_MemtoReg), .i_ALUOp(i_ALUOp),
    .i_RegDst(i_RegDst), .i_Valid(i_Valid), .i_PC4(i_PC4), .i_RData1(i_RData1),
    .i_RData2(i_RData2), .i_Imm32(i_Imm32), .i_Rs(i_Rs), .i_Rt(i_Rt), .i_Rd(i_Rd),
    .i_Shamt(i_Shamt), .i_Flush(i_Flush), .i_Hold(i_Hold),
    .o_RegWr(o_RegWr), .o_Branch(o_Branch), .o_BranchClip(o_BranchClip), .o_Jump(o_Jump),
    .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_ALUSrcA(o_ALUSrcA), .o_ALUSrcB(o_ALUSrcB),
    .o_LuiOp(o_LuiOp), .o_SignedOp(o_SignedOp), .o_MemtoReg(o_MemtoReg), .o_ALUOp(o_ALUOp),
    .o_RegDst(o_RegDst), .o_PC4(o_PC4), .o_RData1(o_RData1), .o_RData2(o_RData2),
    .o_Imm32(o_Imm32), .o_Rs(o_Rs), .o_Rt(o_Rt), .o_Shamt(o_Shamt), .o_WrAddr(o_WrAddr),
    .o_Valid(o_Valid), .o_Stall(o_Stall), .o_StallCnt(o_StallCnt)
  );

  // Free-running 10-unit clock.
  always #5 i_clk = ~i_clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic driveInputs(input idIn_t s);
    i_RegWr = s.regWr;     i_Branch = s.branch;     i_BranchClip = s.branchClip;
    i_Jump = s.jump;       i_MemRead = s.memRead;   i_MemWrite = s.memWrite;
    i_ALUSrcA = s.aluSrcA; i_ALUSrcB = s.aluSrcB;   i_LuiOp = s.luiOp;
    i_SignedOp = s.signedOp; i_MemtoReg = s.memtoReg; i_ALUOp = s.aluOp;
    i_RegDst = s.regDst;   i_Valid = s.valid;       i_PC4 = s.pc4;
    i_RData1 = s.rData1;   i_RData2 = s.rData2;     i_Imm32 = s.imm32;
    i_Rs = s.rs; i_Rt = s.rt; i_Rd = s.rd; i_Shamt = s.shamt;
    i_Flush = s.flush;     i_Hold = s.hold;
  endtask

  function automatic exOut_t sampleDut();
    exOut_t g;
    g = '0;
    g.regWr = o_RegWr;     g.branch = o_Branch;     g.branchClip = o_BranchClip;
    g.jump = o_Jump;       g.memRead = o_MemRead;   g.memWrite = o_MemWrite;
    g.aluSrcA = o_ALUSrcA; g.aluSrcB = o_ALUSrcB;   g.luiOp = o_LuiOp;
    g.signedOp = o_SignedOp; g.memtoReg = o_MemtoReg; g.aluOp = o_ALUOp;
    g.regDst = o_RegDst;   g.pc4 = o_PC4;           g.rData1 = o_RData1;
    g.rData2 = o_RData2;   g.imm32 = o_Imm32;       g.rs = o_Rs;
    g.rt = o_Rt;           g.shamt = o_Shamt;       g.wrAddr = o_WrAddr;
    g.valid = o_Valid;     g.stallCnt = o_StallCnt;
    return g;
  endfunction

  task automatic compareEx(input string where, input exOut_t got, input exOut_t exp);
    checkOutput({where, ".RegWr"},      32'(got.regWr),      32'(exp.regWr));
    checkOutput({where, ".Branch"},     32'(got.branch),     32'(exp.branch));
    checkOutput({where, ".BranchClip"}, 32'(got.branchClip), 32'(exp.branchClip));
    checkOutput({where, ".Jump"},       32'(got.jump),       32'(exp.jump));
    checkOutput({where, ".MemRead"},    32'(got.memRead),    32'(exp.memRead));
    checkOutput({where, ".MemWrite"},   32'(got.memWrite),   32'(exp.memWrite));
    checkOutput({where, ".ALUSrcA"},    32'(got.aluSrcA),    32'(exp.aluSrcA));
    checkOutput({where, ".ALUSrcB"},    32'(got.aluSrcB),    32'(exp.aluSrcB));
    checkOutput({where, ".LuiOp"},      32'(got.luiOp),      32'(exp.luiOp));
    checkOutput({where, ".SignedOp"},   32'(got.signedOp),   32'(exp.signedOp));
    checkOutput({where, ".MemtoReg"},   32'(got.memtoReg),   32'(exp.memtoReg));
    checkOutput({where, ".ALUOp"},      32'(got.aluOp),      32'(exp.aluOp));
    checkOutput({where, ".RegDst"},     32'(got.regDst),     32'(exp.regDst));
    checkOutput({where, ".PC4"},        got.pc4,             exp.pc4);
    checkOutput({where, ".RData1"},     got.rData1,          exp.rData1);
    checkOutput({where, ".RData2"},     got.rData2,          exp.rData2);
    checkOutput({where, ".Imm32"},      got.imm32,           exp.imm32);
    checkOutput({where, ".Rs"},         32'(got.rs),         32'(exp.rs));
    checkOutput({where, ".Rt"},         32'(got.rt),         32'(exp.rt));
    checkOutput({where, ".Shamt"},      32'(got.shamt),      32'(exp.shamt));
    checkOutput({where, ".WrAddr"},     32'(got.wrAddr),     32'(exp.wrAddr));
    checkOutput({where, ".Valid"},      32'(got.valid),      32'(exp.valid));
    checkOutput({where, ".StallCnt"},   32'(got.stallCnt),   32'(exp.stallCnt));
  endtask

  // Drive one ID instruction, check the combinational stall, queue the predicted EX
  // contents and compare them one edge later. Called between edges.
  task automatic applyStimulus(input string tag, input idIn_t s);
    exOut_t nxt, exp;
    logic   luh;
    driveInputs(s);
    luh = mdl.valid && mdl.memRead && (mdl.wrAddr != 5'd0) && s.valid &&
          ((mdl.wrAddr == s.rs) ||
           ((mdl.wrAddr == s.rt) && (!s.aluSrcB || s.memWrite || s.branch)));
    #1 checkOutput({tag, ".Stall"}, 32'(o_Stall), 32'(luh && !s.flush && !s.hold));
    nxt = mdl;
    if (!s.hold) begin
      nxt.regWr = s.regWr;     nxt.branch = s.branch;     nxt.branchClip = s.branchClip;
      nxt.jump = s.jump;       nxt.memRead = s.memRead;   nxt.memWrite = s.memWrite;
      nxt.aluSrcA = s.aluSrcA; nxt.aluSrcB = s.aluSrcB;   nxt.luiOp = s.luiOp;
      nxt.signedOp = s.signedOp; nxt.memtoReg = s.memtoReg; nxt.aluOp = s.aluOp;
      nxt.regDst = s.regDst;   nxt.pc4 = s.pc4;           nxt.rData1 = s.rData1;
      nxt.rData2 = s.rData2;   nxt.imm32 = s.imm32;       nxt.rs = s.rs;
      nxt.rt = s.rt;           nxt.shamt = s.shamt;       nxt.valid = s.valid;
      case (s.regDst)
        2'b00:   nxt.wrAddr = s.rd;
        2'b01:   nxt.wrAddr = s.rt;
        2'b10:   nxt.wrAddr = 5'd31;
        default: nxt.wrAddr = 5'd0;
      endcase
      if (s.flush || luh || !s.valid) begin
        nxt.regWr = 1'b0; nxt.branch = 1'b0; nxt.branchClip = 1'b0; nxt.jump = 1'b0;
        nxt.memRead = 1'b0; nxt.memWrite = 1'b0; nxt.wrAddr = 5'd0; nxt.valid = 1'b0;
      end
      if (!s.flush && luh && (mdl.stallCnt != 16'hFFFF)) nxt.stallCnt = mdl.stallCnt + 16'd1;
    end
    expQ.push_back(nxt);
    @(posedge i_clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      exp = expQ.pop_front();
      mdl = exp;
      compareEx(tag, sampleDut(), exp);
    end
  endtask

  function automatic idIn_t mkLw(input logic [4:0] rt, input logic [4:0] rs);
    idIn_t s = '0;
    s.valid = 1'b1; s.regWr = 1'b1; s.memRead = 1'b1; s.memtoReg = 2'b01;
    s.aluSrcB = 1'b1; s.regDst = 2'b01; s.rt = rt; s.rs = rs;
    s.imm32 = 32'h10; s.pc4 = 32'h200; s.rData1 = 32'h1000;
    return s;
  endfunction

  function automatic idIn_t mkAdd(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    idIn_t s = '0;
    s.valid = 1'b1; s.regWr = 1'b1; s.aluOp = 4'd2; s.regDst = 2'b00;
    s.rs = rs; s.rt = rt; s.rd = rd; s.pc4 = 32'h204;
    s.rData1 = 32'h11; s.rData2 = 32'h22;
    return s;
  endfunction

  function automatic idIn_t mkAddi(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
    idIn_t s = '0;
    s.valid = 1'b1; s.regWr = 1'b1; s.aluSrcB = 1'b1; s.regDst = 2'b01;
    s.rs = rs; s.rt = rt; s.imm32 = imm; s.pc4 = 32'h104; s.signedOp = 1'b1;
    return s;
  endfunction

  function automatic idIn_t mkSw(input logic [4:0] rt, input logic [4:0] rs);
    idIn_t s = '0;
    s.valid = 1'b1; s.memWrite = 1'b1; s.aluSrcB = 1'b1;
    s.rt = rt; s.rs = rs; s.imm32 = 32'h8; s.pc4 = 32'h208;
    return s;
  endfunction

  function automatic idIn_t mkJal();
    idIn_t s = '0;
    s.valid = 1'b1; s.regWr = 1'b1; s.jump = 1'b1; s.regDst = 2'b10;
    s.memtoReg = 2'b10; s.pc4 = 32'h300; s.imm32 = 32'h40;
    return s;
  endfunction

  function automatic idIn_t mkRand();
    idIn_t s = '0;
    s.regWr = 1'($urandom_range(0, 1));   s.branch = 1'($urandom_range(0, 1));
    s.branchClip = 1'($urandom_range(0, 1)); s.jump = 1'($urandom_range(0, 1));
    s.memRead = 1'($urandom_range(0, 1)); s.memWrite = 1'($urandom_range(0, 1));
    s.aluSrcA = 1'($urandom_range(0, 1)); s.aluSrcB = 1'($urandom_range(0, 1));
    s.luiOp = 1'($urandom_range(0, 1));   s.signedOp = 1'($urandom_range(0, 1));
    s.memtoReg = 2'($urandom_range(0, 3)); s.aluOp = 4'($urandom_range(0, 15));
    s.regDst = 2'($urandom_range(0, 3));  s.valid = ($urandom_range(0, 3) != 0);
    s.pc4 = $urandom(); s.rData1 = $urandom(); s.rData2 = $urandom(); s.imm32 = $urandom();
    s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
    s.rd = 5'($urandom_range(0, 3)); s.shamt = 5'($urandom_range(0, 31));
    s.flush = ($urandom_range(0, 7) == 0); s.hold = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  initial begin
    idIn_t  s, lw8;
    logic [15:0] cntBefore;

    // Reset asserted from time zero: everything reads zero with or without clock edges.
    i_rst_n = 1'b0;
    driveInputs('0);
    mdl = '0;
    #3;
    compareEx("resetNoClk", sampleDut(), '0);
    checkOutput("resetNoClk.Stall", 32'(o_Stall), 32'd0);
    repeat (2) @(posedge i_clk);
    #1 compareEx("resetClk", sampleDut(), '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Plain pass: addi $8 = $0 + 5.
    applyStimulus("addi", mkAddi(5'd0, 5'd8, 32'd5));
    checkOutput("addi.WrAddrConst", 32'(o_WrAddr), 32'd8);
    checkOutput("addi.RegWrConst", 32'(o_RegWr), 32'd1);
    checkOutput("addi.Imm32Const", o_Imm32, 32'd5);
    checkOutput("addi.ValidConst", 32'(o_Valid), 32'd1);

    // Load-use: lw $8 then add reading $8 stalls for exactly one cycle.
    lw8 = mkLw(5'd8, 5'd29);
    applyStimulus("lw8", lw8);
    driveInputs(mkAdd(5'd8, 5'd9, 5'd10));
    #1 checkOutput("luh.StallConst", 32'(o_Stall), 32'd1);
    applyStimulus("luhBubble", mkAdd(5'd8, 5'd9, 5'd10));
    checkOutput("luhBubble.ValidConst", 32'(o_Valid), 32'd0);
    checkOutput("luhBubble.CntConst", 32'(o_StallCnt), 32'd1);
    applyStimulus("luhRetry", mkAdd(5'd8, 5'd9, 5'd10));
    checkOutput("luhRetry.ValidConst", 32'(o_Valid), 32'd1);
    checkOutput("luhRetry.WrAddrConst", 32'(o_WrAddr), 32'd10);

    // No false hazard: load to $0, and addi whose rt is only a destination.
    applyStimulus("lw0", mkLw(5'd0, 5'd1));
    driveInputs(mkAdd(5'd0, 5'd0, 5'd3));
    #1 checkOutput("lw0.StallConst", 32'(o_Stall), 32'd0);
    applyStimulus("addAfterLw0", mkAdd(5'd0, 5'd0, 5'd3));
    applyStimulus("lw8b", lw8);
    driveInputs(mkAddi(5'd9, 5'd8, 32'd7));
    #1 checkOutput("addiRt.StallConst", 32'(o_Stall), 32'd0);
    applyStimulus("addiRt", mkAddi(5'd9, 5'd8, 32'd7));

    // A store does read rt, so it must stall.
    applyStimulus("lw8c", lw8);
    applyStimulus("swRt", mkSw(5'd8, 5'd9));
    applyStimulus("swRetry", mkSw(5'd8, 5'd9));

    // Flush and hazard together: flush wins, no stall, counter unchanged.
    applyStimulus("lw8d", lw8);
    cntBefore = mdl.stallCnt;
    s = mkAdd(5'd8, 5'd9, 5'd10);
    s.flush = 1'b1;
    driveInputs(s);
    #1 checkOutput("flush.StallConst", 32'(o_Stall), 32'd0);
    applyStimulus("flushLuh", s);
    checkOutput("flush.ValidConst", 32'(o_Valid), 32'd0);
    checkOutput("flush.CntConst", 32'(o_StallCnt), 32'(cntBefore));

    // Hold for three cycles with changing inputs (including a hazard), then jal.
    applyStimulus("lw8e", lw8);
    for (int i = 0; i < 3; i++) begin
      s = mkAdd(5'd8, 5'(i + 1), 5'(i + 12));
      s.hold = 1'b1;
      s.flush = (i == 1);
      s.pc4 = 32'h900 + 32'(i);
      applyStimulus("hold", s);
      checkOutput("hold.PC4Const", o_PC4, 32'h200);
      checkOutput("hold.WrAddrConst", 32'(o_WrAddr), 32'd8);
    end
    applyStimulus("jal", mkJal());
    checkOutput("jal.WrAddrConst", 32'(o_WrAddr), 32'd31);

    // Randomised mix of instructions, flushes and holds against the model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand", mkRand());
    end

    // Saturation: jump the counter to its ceiling instead of spending 131k cycles on real stalls.
    applyStimulus("lw8sat", lw8);
    force dut.stallCnt_q = 16'hFFFF;
    mdl.stallCnt = 16'hFFFF;
    applyStimulus("satHazard", mkAdd(5'd8, 5'd9, 5'd10));
    release dut.stallCnt_q;
    #1 checkOutput("satRelease.CntConst", 32'(o_StallCnt), 32'hFFFF);
    applyStimulus("lw8sat2", lw8);
    applyStimulus("satHazard2", mkAdd(5'd8, 5'd9, 5'd10));
    checkOutput("satHazard2.CntConst", 32'(o_StallCnt), 32'hFFFF);

    // Reset mid-stall: outputs clear between edges and the stall drops.
    applyStimulus("lw8rst", lw8);
    driveInputs(mkAdd(5'd8, 5'd9, 5'd10));
    #1 checkOutput("preRst.StallConst", 32'(o_Stall), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    compareEx("midReset", sampleDut(), '0);
    checkOutput("midReset.Stall", 32'(o_Stall), 32'd0);
    mdl = '0;
    expQ.delete();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    applyStimulus("postReset", mkAddi(5'd0, 5'd8, 32'd5));
    checkOutput("postReset.CntConst", 32'(o_StallCnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
